// File: rtl/clk_freq_meter.sv
// clk_freq_meter: measures the frequency and period of an asynchronous signal
// using the system clock.
//
// sig_in is synchronised, and its rising edges are counted over a window of
// GATE_CYCLES clk_in cycles. The window starts on an edge. The interval between
// the last two edges in the window is also reported.
//
// Optional feature: define FREQ_METER_DUTY_EN to build the high-time counter.
// Without it, high_cycles is tied to 0.
//
// Ports:
//   clk_in        system clock
//   reset_n       asynchronous active-low reset
//   sig_in        asynchronous signal under measurement
//   start         single-shot request, only honoured in IDLE
//   continuous    level; repeat measurements back-to-back while high
//   freq_count    rising edges counted in the last gate window
//   period_cycles clk_in cycles between the last two rising edges, 0 if unknown
//   high_cycles   gate cycles with synchronised sig_in high (duty feature)
//   valid         one-cycle pulse when results update
//   busy          high in every state except IDLE
//   no_signal     last measurement timed out waiting for the first edge
//   overflow      last measurement saturated a counter
module clk_freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq_count,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             valid,
  output logic             busy,
  output logic             no_signal,
  output logic             overflow
);

  localparam int unsigned     TmrW    = $clog2(GATE_CYCLES + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StArm, StGate, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced, rise;

  // Shared timer: ARM timeout, then gate cycle index (0-based).
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             edge_sat_q, edge_sat_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             per_sat_q, per_sat_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             shadow_sat_q, shadow_sat_d;
  logic             per_valid_q, per_valid_d;

  logic [CNT_W-1:0] freq_q, freq_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             nosig_q, nosig_d;
  logic             ovf_q, ovf_d;

  logic load_res, load_ns;
  logic gate_clr, in_gate;
  logic high_ovf;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~prev_q;
  assign gate_clr = (state_q == StArm) & rise;
  assign in_gate  = (state_q == StGate);

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    edge_d       = edge_q;
    edge_sat_d   = edge_sat_q;
    per_d        = per_q;
    per_sat_d    = per_sat_q;
    shadow_d     = shadow_q;
    shadow_sat_d = shadow_sat_q;
    per_valid_d  = per_valid_q;
    load_res     = 1'b0;
    load_ns      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start || continuous) begin
          state_d = StArm;
          tmr_d   = '0;
        end
      end
      StArm: begin
        if (rise) begin
          state_d      = StGate;
          tmr_d        = '0;
          edge_d       = '0;
          edge_sat_d   = 1'b0;
          // The arming edge is the period reference; gate cycle 1 is one cycle after it.
          per_d        = CNT_W'(1);
          per_sat_d    = 1'b0;
          shadow_d     = '0;
          shadow_sat_d = 1'b0;
          per_valid_d  = 1'b0;
        end else if (tmr_q == TmrLast) begin
          state_d = StDone;
          load_ns = 1'b1;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StGate: begin
        if (rise) begin
          if (edge_q == CntMax) edge_sat_d = 1'b1;
          else                  edge_d     = edge_q + CNT_W'(1);
          shadow_d     = per_q;
          shadow_sat_d = per_sat_q;
          per_valid_d  = 1'b1;
          per_d        = CNT_W'(1);
          per_sat_d    = 1'b0;
        end else if (per_q == CntMax) begin
          per_sat_d = 1'b1;
        end else begin
          per_d = per_q + CNT_W'(1);
        end
        if (tmr_q == TmrLast) begin
          state_d  = StDone;
          load_res = 1'b1;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StDone: begin
        state_d = continuous ? StArm : StIdle;
        tmr_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Results load on entry to DONE, so they are visible alongside valid.
  always_comb begin
    freq_d   = freq_q;
    period_d = period_q;
    nosig_d  = nosig_q;
    ovf_d    = ovf_q;
    if (load_ns) begin
      freq_d   = '0;
      period_d = '0;
      nosig_d  = 1'b1;
      ovf_d    = 1'b0;
    end else if (load_res) begin
      freq_d   = edge_d;
      period_d = per_valid_d ? shadow_d : '0;
      nosig_d  = 1'b0;
      ovf_d    = edge_sat_d | (per_valid_d & shadow_sat_d) | high_ovf;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      tmr_q        <= '0;
      edge_q       <= '0;
      edge_sat_q   <= 1'b0;
      per_q        <= '0;
      per_sat_q    <= 1'b0;
      shadow_q     <= '0;
      shadow_sat_q <= 1'b0;
      per_valid_q  <= 1'b0;
      freq_q       <= '0;
      period_q     <= '0;
      nosig_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q       <= synced;
      tmr_q        <= tmr_d;
      edge_q       <= edge_d;
      edge_sat_q   <= edge_sat_d;
      per_q        <= per_d;
      per_sat_q    <= per_sat_d;
      shadow_q     <= shadow_d;
      shadow_sat_q <= shadow_sat_d;
      per_valid_q  <= per_valid_d;
      freq_q       <= freq_d;
      period_q     <= period_d;
      nosig_q      <= nosig_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0] high_q, high_d;
  logic             high_sat_q, high_sat_d;
  logic [CNT_W-1:0] high_out_q, high_out_d;

  always_comb begin
    high_d     = high_q;
    high_sat_d = high_sat_q;
    high_out_d = high_out_q;
    if (gate_clr) begin
      high_d     = '0;
      high_sat_d = 1'b0;
    end else if (in_gate && synced) begin
      if (high_q == CntMax) high_sat_d = 1'b1;
      else                  high_d     = high_q + CNT_W'(1);
    end
    if (load_ns)       high_out_d = '0;
    else if (load_res) high_out_d = high_d;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      high_q     <= '0;
      high_sat_q <= 1'b0;
      high_out_q <= '0;
    end else begin
      high_q     <= high_d;
      high_sat_q <= high_sat_d;
      high_out_q <= high_out_d;
    end
  end

  assign high_cycles = high_out_q;
  assign high_ovf    = high_sat_d;
`else
  assign high_cycles = '0;
  assign high_ovf    = 1'b0;
`endif

  assign freq_count    = freq_q;
  assign period_cycles = period_q;
  assign no_signal     = nosig_q;
  assign overflow      = ovf_q;
  assign valid         = (state_q == StDone);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Testbench for clk_freq_meter: a main instance (GATE_CYCLES=1000, CNT_W=32)
// plus two 8-bit instances used for the saturation cases.
module tb_clk_freq_meter;

`ifdef FREQ_METER_DUTY_EN
  localparam bit Duty = 1'b1;
`else
  localparam bit Duty = 1'b0;
`endif

  typedef struct {
    bit          chk;
    logic [31:0] freq;
    logic [31:0] per;
    logic [31:0] high;
    logic        ns;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sig_in = 1'b0;
  logic start_m = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic cont_m = 1'b0;
  logic cont_s = 1'b0;
  int   half = 0;
  int   ph = 0;

  logic [31:0] freq_m, per_m, high_m;
  logic        valid_m, busy_m, ns_m, ovf_m;
  logic [7:0]  freq_a, per_a, high_a;
  logic        valid_a, busy_a, ns_a, ovf_a;
  logic [7:0]  freq_b, per_b, high_b;
  logic        valid_b, busy_b, ns_b, ovf_b;

  exp_t q_m[$];
  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  clk_freq_meter #(.GATE_CYCLES(1000), .CNT_W(32), .SYNC_STAGES(2)) u_main (
    .clk_in(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start_m), .continuous(cont_m),
    .freq_count(freq_m), .period_cycles(per_m), .high_cycles(high_m), .valid(valid_m),
    .busy(busy_m), .no_signal(ns_m), .overflow(ovf_m)
  );

  clk_freq_meter #(.GATE_CYCLES(2000), .CNT_W(8), .SYNC_STAGES(2)) u_sat_a (
    .clk_in(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start_a), .continuous(cont_s),
    .freq_count(freq_a), .period_cycles(per_a), .high_cycles(high_a), .valid(valid_a),
    .busy(busy_a), .no_signal(ns_a), .overflow(ovf_a)
  );

  clk_freq_meter #(.GATE_CYCLES(400), .CNT_W(8), .SYNC_STAGES(2)) u_sat_b (
    .clk_in(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start_b), .continuous(cont_s),
    .freq_count(freq_b), .period_cycles(per_b), .high_cycles(high_b), .valid(valid_b),
    .busy(busy_b), .no_signal(ns_b), .overflow(ovf_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string who, input exp_t e, input logic [31:0] f,
                           input logic [31:0] p, input logic [31:0] h, input logic ns,
                           input logic ov);
    check_val({who, ".freq"}, f, e.freq);
    check_val({who, ".period"}, p, e.per);
    check_val({who, ".high"}, h, e.high);
    check_val({who, ".no_signal"}, 32'(ns), 32'(e.ns));
    check_val({who, ".overflow"}, 32'(ov), 32'(e.ovf));
  endtask

  function automatic exp_t mk(input bit chk, input int f, input int p, input int h,
                              input bit ns, input bit ov);
    exp_t e;
    e.chk = chk; e.freq = f; e.per = p; e.high = Duty ? h : 0; e.ns = ns; e.ovf = ov;
    return e;
  endfunction

  // Signal source: toggles every `half` clk cycles, held low when half is 0.
  initial begin
    forever begin
      @(negedge clk);
      if (half == 0) begin
        sig_in = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= half) begin
          sig_in = ~sig_in;
          ph = 0;
        end
      end
    end
  end

  // Scoreboard monitors.
  always @(negedge clk) begin
    exp_t e;
    if (valid_m) begin
      if (q_m.size() == 0) check_val("main.unexpected_valid", 32'(valid_m), 32'd0);
      else begin
        e = q_m.pop_front();
        if (e.chk) check_res("main", e, freq_m, per_m, high_m, ns_m, ovf_m);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid_a) begin
      if (q_a.size() == 0) check_val("sat_a.unexpected_valid", 32'(valid_a), 32'd0);
      else begin
        e = q_a.pop_front();
        if (e.chk) check_res("sat_a", e, 32'(freq_a), 32'(per_a), 32'(high_a), ns_a, ovf_a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid_b) begin
      if (q_b.size() == 0) check_val("sat_b.unexpected_valid", 32'(valid_b), 32'd0);
      else begin
        e = q_b.pop_front();
        if (e.chk) check_res("sat_b", e, 32'(freq_b), 32'(per_b), 32'(high_b), ns_b, ovf_b);
      end
    end
  end

  task automatic wait_empty(input string tag, input int maxc);
    int n = 0;
    while ((q_m.size() + q_a.size() + q_b.size()) != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, ".pending"}, 32'(q_m.size() + q_a.size() + q_b.size()), 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int n;
    half = 2;
    #1;
    check_val("reset.freq", freq_m, 0);
    check_val("reset.period", per_m, 0);
    check_val("reset.high", high_m, 0);
    check_val("reset.flags", {28'd0, valid_m, busy_m, ns_m, ovf_m}, 0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(20);

    // Period 4 on all three instances; 8-bit G=2000 saturates, G=400 does not.
    q_m.push_back(mk(1, 250, 4, 500, 0, 0));
    q_a.push_back(mk(1, 255, 4, 255, 0, 1));
    q_b.push_back(mk(1, 100, 4, 200, 0, 0));
    start_m = 1'b1; start_a = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_m = 1'b0; start_a = 1'b0; start_b = 1'b0;
    wait_empty("p4", 3000);
    wait_cycles(3);
    check_val("p4.busy_after", {30'd0, busy_m, busy_b}, 0);

    // Fastest input: period 2.
    half = 1;
    wait_cycles(20);
    q_m.push_back(mk(1, 500, 2, 500, 0, 0));
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_empty("p2", 1500);

    // No signal: timeout exactly 1000 cycles after ARM entry.
    half = 0;
    wait_cycles(20);
    q_m.push_back(mk(1, 0, 0, 0, 1, 0));
    start_m = 1'b1;
    @(posedge clk);
    #1 start_m = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_m && n < 2000);
    check_val("nosig.latency", 32'(n), 32'd1001);
    @(negedge clk);
    check_val("nosig.busy_after", 32'(busy_m), 32'd0);
    wait_empty("nosig", 10);

    // Continuous mode, period 10; sat_a reruns to clear its overflow.
    half = 5;
    wait_cycles(30);
    for (int i = 0; i < 3; i++) q_m.push_back(mk(1, 100, 10, 500, 0, 0));
    q_a.push_back(mk(1, 200, 10, 255, 0, Duty));
    cont_m = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_empty("cont10", 5000);
    check_val("cont10.busy", 32'(busy_m), 32'd1);
    // Switch to period 20: the straddling window is not checked.
    half = 10;
    q_m.push_back(mk(0, 0, 0, 0, 0, 0));
    q_m.push_back(mk(1, 50, 20, 500, 0, 0));
    wait_empty("cont20", 3000);
    wait_cycles(500);
    cont_m = 1'b0;
    q_m.push_back(mk(1, 50, 20, 500, 0, 0));
    wait_empty("cont_drop", 2000);
    wait_cycles(2);
    check_val("cont_drop.busy", 32'(busy_m), 32'd0);

    // Reset during GATE aborts with no valid pulse.
    half = 2;
    wait_cycles(20);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_cycles(500);
    check_val("abort.busy_before", 32'(busy_m), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("abort.freq", freq_m, 0);
    check_val("abort.period", per_m, 0);
    check_val("abort.flags", {28'd0, valid_m, busy_m, ns_m, ovf_m}, 0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(10);
    q_m.push_back(mk(1, 250, 4, 500, 0, 0));
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_empty("fresh", 1500);
    wait_cycles(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
